// File: rtl/range_counter_pkg.sv
// Shared types and reset-default constants for the range_counter family.
package range_counter_pkg;

  typedef enum logic [1:0] {
    WRAP_UP = 2'b00,
    WRAP_DN = 2'b01,
    BOUNCE  = 2'b10,
    SAT_UP  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    UP   = 2'b00,
    DOWN = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam int LO_DEF_C = 10;
  localparam int HI_DEF_C = 40;

  // State a mode starts in after load, range correction or a mode switch.
  function automatic state_e entry_state(input mode_e m);
    return (m == WRAP_DN) ? DOWN : UP;
  endfunction

endpackage

// File: rtl/range_counter_cfg.sv
// Bound registers for range_counter: holds lo/hi, the invalid-config flag
// and the compare flags of the current count against the live bounds.
module range_counter_cfg
  import range_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LO_DEF = LO_DEF_C,
  parameter int HI_DEF = HI_DEF_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] lo_r,
  output logic [WIDTH-1:0] hi_r,
  output logic             cfg_err,
  output logic             below_lo,
  output logic             above_hi,
  output logic             at_lo,
  output logic             at_hi
);

  // Capture new bounds; cfg_err is computed from the written values so it
  // always equals (lo_r > hi_r) in the same cycle the bounds change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lo_r    <= WIDTH'(LO_DEF);
      hi_r    <= WIDTH'(HI_DEF);
      cfg_err <= 1'b0;
    end else if (cfg_we) begin
      lo_r    <= lo_in;
      hi_r    <= hi_in;
      cfg_err <= (lo_in > hi_in);
    end
  end

  // Position of the registered count relative to the registered bounds.
  always_comb begin
    below_lo = (count < lo_r);
    above_hi = (count > hi_r);
    at_lo    = (count == lo_r);
    at_hi    = (count == hi_r);
  end

endmodule

// File: rtl/range_counter.sv
// Bounded up/down/bounce/saturate counter with programmable bounds.
// Define RANGE_COUNTER_WRAP_CNT_EN to add the 16-bit wrap_cnt output that
// counts terminal-count events.
module range_counter
  import range_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LO_DEF = LO_DEF_C,
  parameter int HI_DEF = HI_DEF_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] hi_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             dir_up,
  output logic             done,
  output logic             cfg_err
`ifdef RANGE_COUNTER_WRAP_CNT_EN
  ,
  output logic [15:0]      wrap_cnt
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] lo_r, hi_r;
  logic             below_lo, above_hi, at_lo, at_hi;
  mode_e            mode_m, mode_q;
  state_e           state, eff, step_state, entry;
  logic             mode_chg, term, step_done;
  logic [WIDTH-1:0] step_cnt;

  range_counter_cfg #(
    .WIDTH (WIDTH),
    .LO_DEF(LO_DEF),
    .HI_DEF(HI_DEF)
  ) u_cfg (
    .clk     (clk),
    .rst     (rst),
    .cfg_we  (cfg_we),
    .lo_in   (lo_in),
    .hi_in   (hi_in),
    .count   (count),
    .lo_r    (lo_r),
    .hi_r    (hi_r),
    .cfg_err (cfg_err),
    .below_lo(below_lo),
    .above_hi(above_hi),
    .at_lo   (at_lo),
    .at_hi   (at_hi)
  );

  assign mode_m   = mode_e'(mode);
  assign mode_chg = (mode_m != mode_q);
  assign entry    = entry_state(mode_m);

  // Effective direction for this edge: a mode switch (or leaving HOLD after
  // a config error) restarts the mode; saturate stays parked once done.
  always_comb begin
    eff = entry;
    case (mode_m)
      BOUNCE:  if (!mode_chg && state != HOLD) eff = state;
      SAT_UP:  if (!mode_chg && done) eff = HOLD;
      default: ;
    endcase
  end

  // Enabled-count successor. Every +1/-1 is guarded by an at-bound test, so
  // full-range bounds never over- or underflow.
  always_comb begin
    step_cnt   = count;
    step_state = eff;
    step_done  = 1'b0;
    case (mode_m)
      WRAP_UP: step_cnt = at_hi ? lo_r : count + ONE;
      WRAP_DN: step_cnt = at_lo ? hi_r : count - ONE;
      BOUNCE: begin
        if (eff == DOWN) begin
          if (!at_lo) step_cnt = count - ONE;
          else if (!at_hi) begin
            step_cnt   = lo_r + ONE;
            step_state = UP;
          end
        end else begin
          if (!at_hi) step_cnt = count + ONE;
          else if (!at_lo) begin
            step_cnt   = hi_r - ONE;
            step_state = DOWN;
          end
        end
      end
      SAT_UP: begin
        if (eff == HOLD || at_hi) begin
          step_state = HOLD;
          step_done  = 1'b1;
        end else begin
          step_cnt = count + ONE;
        end
      end
      default: ;
    endcase
  end

  // Terminal count from registered state; suppressed by load and bad config.
  always_comb begin
    case (state)
      UP:      term = at_hi;
      DOWN:    term = at_lo;
      default: term = 1'b0;
    endcase
    tc = en & ~cfg_err & ~load & ~done & term;
  end

  // Direction FSM and count register, in edge priority order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= WIDTH'(LO_DEF);
      state  <= UP;
      dir_up <= 1'b1;
      done   <= 1'b0;
      mode_q <= WRAP_UP;
    end else begin
      mode_q <= mode_m;
      if (cfg_err) begin
        count  <= lo_r;
        state  <= HOLD;
        dir_up <= 1'b0;
        done   <= 1'b0;
      end else if (load) begin
        count  <= load_val;
        state  <= entry;
        dir_up <= (entry == UP);
        done   <= 1'b0;
      end else if (below_lo || above_hi) begin
        count  <= (mode_m == WRAP_DN) ? hi_r : lo_r;
        state  <= entry;
        dir_up <= (entry == UP);
        done   <= 1'b0;
      end else if (en) begin
        count  <= step_cnt;
        state  <= step_state;
        dir_up <= (step_state == UP);
        done   <= step_done;
      end else begin
        state  <= eff;
        dir_up <= (eff == UP);
        done   <= (eff == HOLD);
      end
    end
  end

`ifdef RANGE_COUNTER_WRAP_CNT_EN
  // Terminal-count event counter; rolls over naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst)      wrap_cnt <= 16'd0;
    else if (load) wrap_cnt <= 16'd0;
    else if (tc)   wrap_cnt <= wrap_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_range_counter.sv
// Scoreboard bench for range_counter: stimulus pushes hand-computed
// post-edge expectations; a monitor pops and compares one per clock.
module tb_range_counter;
  import range_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, cfg_we, load;
  logic [1:0] mode;
  logic [7:0] lo_in, hi_in, load_val;
  logic [7:0] count;
  logic       tc, dir_up, done, cfg_err;
`ifdef RANGE_COUNTER_WRAP_CNT_EN
  logic [15:0] wrap_cnt;
`endif

  range_counter #(.WIDTH(8), .LO_DEF(10), .HI_DEF(40)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .cfg_we  (cfg_we),
    .lo_in   (lo_in),
    .hi_in   (hi_in),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .tc      (tc),
    .dir_up  (dir_up),
    .done    (done),
    .cfg_err (cfg_err)
`ifdef RANGE_COUNTER_WRAP_CNT_EN
    ,
    .wrap_cnt(wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int cnt;
    int tc;
    int dir;
    int dn;
    int err;
    int wc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   next_id = 0;

  // Negative expectation means "don't care" for that field.
  task automatic chk(input int id, input string name, input int act, input int exp);
    if (exp >= 0) begin
      vectors++;
      if (act != exp) begin
        errors++;
        $display("FAIL vec%0d %s: got %0d expected %0d", id, name, act, exp);
      end
    end
  endtask

  // Queue the expected post-edge outputs for the inputs now applied.
  task automatic cyc(input int c, input int t, input int d, input int dn,
                     input int e, input int wc = -1);
    exp_t x;
    x.id = next_id++; x.cnt = c; x.tc = t; x.dir = d; x.dn = dn; x.err = e; x.wc = wc;
    q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: one expectation per edge, sampled just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk(x.id, "count",   int'(count),   x.cnt);
        chk(x.id, "tc",      int'(tc),      x.tc);
        chk(x.id, "dir_up",  int'(dir_up),  x.dir);
        chk(x.id, "done",    int'(done),    x.dn);
        chk(x.id, "cfg_err", int'(cfg_err), x.err);
`ifdef RANGE_COUNTER_WRAP_CNT_EN
        chk(x.id, "wrap_cnt", int'(wrap_cnt), x.wc);
`endif
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'd0; cfg_we = 1'b0;
    lo_in = 8'd0; hi_in = 8'd0; load = 1'b0; load_val = 8'd0;

    // Reset state
    cyc(10, 0, 1, 0, 0, 0);

    // Wrap-up with default bounds: 11..40 then back to 10
    rst = 1'b1; en = 1'b1;
    for (int k = 1; k <= 31; k++)
      cyc((k == 31) ? 10 : 10 + k, (k == 30) ? 1 : 0, 1, 0, 0, (k == 31) ? 1 : -1);

    // Out-of-range load, then correction
    en = 1'b0; load = 1'b1; load_val = 8'd50; cyc(50, 0, 1, 0, 0);
    load = 1'b0;                               cyc(10, 0, 1, 0, 0);
    // Load beats enable
    en = 1'b1; load = 1'b1; load_val = 8'd20;  cyc(20, 0, 1, 0, 0);
    en = 1'b0; load = 1'b0;                    cyc(20, 0, 1, 0, 0);
    // Wrap-down correction to hi
    load = 1'b1; load_val = 8'd50;             cyc(50, 0, 1, 0, 0);
    load = 1'b0; mode = 2'd1;                  cyc(40, 0, 0, 0, 0);
    en = 1'b1;                                 cyc(39, 0, 0, 0, 0);
    load = 1'b1; load_val = 8'd11;             cyc(11, 0, 0, 0, 0);
    load = 1'b0;                               cyc(10, 1, 0, 0, 0);
    cyc(40, 0, 0, 0, 0);

    // Bounce between 3 and 6
    en = 1'b0; mode = 2'd2; cfg_we = 1'b1; lo_in = 8'd3; hi_in = 8'd6;
    cyc(40, 0, 1, 0, 0);
    cfg_we = 1'b0; cyc(3, 0, 1, 0, 0);
    en = 1'b1;
    cyc(4, 0, 1, 0, 0);
    cyc(5, 0, 1, 0, 0);
    cyc(6, 1, 1, 0, 0);
    cyc(5, 0, 0, 0, 0);
    cyc(4, 0, 0, 0, 0);
    cyc(3, 1, 0, 0, 0);
    cyc(4, 0, 1, 0, 0);

    // Saturate over the full 8-bit range
    en = 1'b0; mode = 2'd3; cfg_we = 1'b1; lo_in = 8'd0; hi_in = 8'd255;
    cyc(4, 0, 1, 0, 0);
    cfg_we = 1'b0; load = 1'b1; load_val = 8'd250; cyc(250, 0, 1, 0, 0);
    load = 1'b0; en = 1'b1;
    cyc(251, 0, 1, 0, 0);
    cyc(252, 0, 1, 0, 0);
    cyc(253, 0, 1, 0, 0);
    cyc(254, 0, 1, 0, 0);
    cyc(255, 1, 1, 0, 0);
    cyc(255, 0, 0, 1, 0);
    cyc(255, 0, 0, 1, 0);
    load = 1'b1; load_val = 8'd7; cyc(7, 0, 1, 0, 0);
    load = 1'b0;                  cyc(8, 0, 1, 0, 0);

    // Invalid bounds, then recovery
    mode = 2'd0; cfg_we = 1'b1; lo_in = 8'd20; hi_in = 8'd5;
    cyc(9, 0, 1, 0, 1);
    cfg_we = 1'b0; cyc(20, 0, 0, 0, 1);
    cyc(20, 0, 0, 0, 1);
    cfg_we = 1'b1; lo_in = 8'd5; hi_in = 8'd20;
    cyc(20, 0, 0, 0, 0);
    cfg_we = 1'b0; cyc(5, 0, 1, 0, 0);
    cyc(6, 0, 1, 0, 0);

    // Mid-run reset while bouncing down
    en = 1'b0; mode = 2'd2; cfg_we = 1'b1; lo_in = 8'd10; hi_in = 8'd40;
    cyc(6, 0, 1, 0, 0);
    cfg_we = 1'b0; load = 1'b1; load_val = 8'd40; cyc(40, 0, 1, 0, 0);
    load = 1'b0; en = 1'b1;
    for (int k = 1; k <= 15; k++) cyc(40 - k, 0, 0, 0, 0);
    rst = 1'b0; cyc(10, 0, 1, 0, 0, 0);
    rst = 1'b1; cyc(11, 0, 1, 0, 0);

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/range_counter.md
Name: range_counter

Overview:
- Parametrised, self-correcting bounded counter; successor to the fixed 10-to-40 up counter.
- Runtime-programmable lower/upper bounds, four counting modes (wrap-up, wrap-down, bounce, saturate), count enable, parallel load, terminal-count pulse and config-error flag.
- Used as a generic sequencer/timebase inside the Counters library.

Parameters:
- WIDTH, 8, count/bound width in bits.
- LO_DEF, 10, lower bound loaded at reset.
- HI_DEF, 40, upper bound loaded at reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  count enable.
- mode  in  2  00 wrap-up, 01 wrap-down, 10 bounce, 11 saturate-up.
- cfg_we  in  1  capture lo_in/hi_in into bound registers.
- lo_in  in  WIDTH  new lower bound.
- hi_in  in  WIDTH  new upper bound.
- load  in  1  parallel load request.
- load_val  in  WIDTH  value for load.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count indication, combinational from registered state.
- dir_up  out  1  current direction (1 = up), registered.
- done  out  1  saturate mode reached hi, registered.
- cfg_err  out  1  bounds invalid (lo > hi), registered.

Behaviour:
- Reset (rst=0 at edge): lo_r=LO_DEF, hi_r=HI_DEF, count=LO_DEF, state=UP, dir_up=1, done=0, cfg_err=0; tc=0 follows from en=0 or non-terminal count.
- Bound registers:
  - cfg_we=1 writes lo_r/hi_r at the edge; new bounds take effect for the following cycle's evaluation.
  - cfg_err=1 whenever lo_r > hi_r; lo_r==hi_r is legal.
- Per-edge priority: rst > cfg_err hold > load > range correction > enabled count.
  - cfg_err=1: count forced to lo_r, state HOLD, tc=0.
  - load=1: count=load_val regardless of en; done cleared. An out-of-range load_val is corrected on the next edge.
  - Range correction (count<lo_r or count>hi_r), applied regardless of en:
    - Modes 00, 10, 11: count=lo_r, state=UP.
    - Mode 01: count=hi_r, state=DOWN.
  - en=0: count holds.
- Direction FSM states: UP, DOWN, HOLD.
  - Mode 00: state UP; count+1; at hi_r next=lo_r.
  - Mode 01: state DOWN; count-1; at lo_r next=hi_r.
  - Mode 10: UP increments until hi_r, then next=hi_r-1 and state=DOWN. DOWN decrements until lo_r, then next=lo_r+1 and state=UP. If lo_r==hi_r, count holds at lo_r and tc asserts every enabled cycle.
  - Mode 11: UP increments to hi_r, then state=HOLD and done=1. HOLD keeps count; exit only via load, mode change or rst.
  - A mode change mid-count re-enters that mode's state on the next edge, keeping count if in range.
- tc = en & ~cfg_err & ~load & count at its terminal value:
  - hi_r in UP.
  - lo_r in DOWN.
  - hi_r for mode 11 before done; never while done=1.
- Arithmetic: unsigned, WIDTH bits. Wrap to bounds is explicit, so no natural overflow is ever used. hi_r=2^WIDTH-1 and lo_r=0 must be handled without overflow.
- dir_up = (state==UP).

Optional Feature:
- Macro: RANGE_COUNTER_WRAP_CNT_EN.
- Defined:
  - Adds output wrap_cnt [15:0], reset 0.
  - Increments on every edge where tc=1; wraps 0xFFFF to 0.
  - Cleared by load.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package range_counter_pkg holds:
  - typedef mode_e (WRAP_UP, WRAP_DN, BOUNCE, SAT_UP).
  - typedef state_e (UP, DOWN, HOLD).
  - constants LO_DEF_C=10, HI_DEF_C=40.
- Sub-module range_counter_cfg holds lo_r/hi_r, cfg_err and the in-range compare flags (below_lo, above_hi, at_lo, at_hi).
- The top holds the FSM and the count datapath.

Test Plan:
- Reset, en=1, mode 00, defaults: count 10,11,…,40,10. tc=1 only while count=40. cfg_err=0.
- Mode 10, cfg_we lo=3 hi=6: count 3,4,5,6,5,4,3,4. dir_up falls after 6 and rises after 3. tc at 6 and at 3.
- Mode 11, lo=0 hi=255 (WIDTH=8): reaches 255 without overflow, then done=1, count holds, tc=0. load_val=7 restarts at 7 with done=0.
- Out-of-range and priority:
  - en=0, load_val=50 with defaults: next edge count=50, following edge corrected to 10.
  - Mode 01 with count=50: corrected to 40.
  - load and en together: load wins.
- Invalid config lo=20 hi=5: cfg_err=1, count=20, tc=0. Rewrite lo=5 hi=20: cfg_err=0, counting resumes from 5.
- Mid-run rst=0 at count=25 in mode 10 DOWN: next edge count=10, dir_up=1, done=0. With the macro, wrap_cnt=0.
